router_switch_ctrl: RTL

//  Switch-allocation controller for the 5-port XY mesh router (EAST=0 WEST=1 NORTH=2 SOUTH=3 LOCAL=4).

---
 rtl/router_switch_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/router_switch_ctrl.sv
// Switch-allocation controller for the 5-port XY mesh router: round-robin header arbitration,
// XY route computation, output allocation/release. Optional per-output grant counters via ROUTER_GRANT_CNT_EN.
module router_switch_ctrl #(
    parameter int unsigned NPORT      = 5,
    parameter int unsigned FLIT_WIDTH = 16,
    parameter logic [7:0]  ADDRESS    = 8'h00
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NPORT-1:0]            h,
    input  logic [NPORT*FLIT_WIDTH-1:0] header,
    input  logic [NPORT-1:0]            sender,
    output logic [NPORT-1:0]            ack_h,
    output logic [NPORT*3-1:0]          mux_in,
    output logic [NPORT*3-1:0]          mux_out,
    output logic [NPORT-1:0]            free
`ifdef ROUTER_GRANT_CNT_EN
    ,
    output logic [NPORT*16-1:0]         grant_cnt
`endif
);

    localparam int unsigned PW = 3;
    localparam int unsigned CW = 16;

    localparam logic [PW-1:0] P_EAST  = PW'(0);
    localparam logic [PW-1:0] P_WEST  = PW'(1);
    localparam logic [PW-1:0] P_NORTH = PW'(2);
    localparam logic [PW-1:0] P_SOUTH = PW'(3);
    localparam logic [PW-1:0] P_LOCAL = PW'(4);

    localparam logic [3:0] LX = ADDRESS[7:4];
    localparam logic [3:0] LY = ADDRESS[3:0];

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_ROUTE, S_GRANT} state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [PW-1:0]        sel_q, sel_d;
    logic [PW-1:0]        dir_q, dir_d;
    logic [7:0]           hdr_q, hdr_d;
    logic [NPORT-1:0]     ack_q, ack_d;
    logic [NPORT-1:0]     free_q, free_d;
    logic [NPORT*PW-1:0]  mux_in_q, mux_in_d;
    logic [NPORT*PW-1:0]  mux_out_q, mux_out_d;
    logic [NPORT-1:0]     sender_q;
`ifdef ROUTER_GRANT_CNT_EN
    logic [NPORT*CW-1:0]  cnt_q, cnt_d;
`endif

    logic [NPORT-1:0]     elig;
    logic                 arb_found;
    logic [PW-1:0]        arb_sel;
    logic [PW-1:0]        arb_idx;
    logic [PW-1:0]        route_dir;
    logic [7:0]           dest [NPORT];
    logic                 unused_hdr;

    assign elig       = h & ~sender;
    assign unused_hdr = ^header;

    for (genvar g = 0; g < NPORT; g++) begin : g_dest
        assign dest[g] = header[g*FLIT_WIDTH +: 8];
    end

    // Round-robin: first eligible input after the pointer, wrapping modulo NPORT
    always_comb begin
        arb_found = 1'b0;
        arb_sel   = ptr_q;
        arb_idx   = '0;
        for (int unsigned k = 1; k <= NPORT; k++) begin
            arb_idx = PW'((32'(ptr_q) + k) % NPORT);
            if (!arb_found && elig[arb_idx]) begin
                arb_found = 1'b1;
                arb_sel   = arb_idx;
            end
        end
    end

    // XY dimension-order routing on the latched destination
    always_comb begin
        route_dir = P_LOCAL;
        if (hdr_q[7:4] > LX)      route_dir = P_EAST;
        else if (hdr_q[7:4] < LX) route_dir = P_WEST;
        else if (hdr_q[3:0] > LY) route_dir = P_NORTH;
        else if (hdr_q[3:0] < LY) route_dir = P_SOUTH;
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        dir_d     = dir_q;
        hdr_d     = hdr_q;
        ack_d     = '0;
        free_d    = free_q;
        mux_in_d  = mux_in_q;
        mux_out_d = mux_out_q;
`ifdef ROUTER_GRANT_CNT_EN
        cnt_d     = cnt_q;
`endif

        // Tail sent: release whatever output this input was last connected to
        for (int unsigned i = 0; i < NPORT; i++) begin
            if (sender_q[i] && !sender[i]) begin
                free_d[mux_out_q[i*PW +: PW]] = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (|elig) state_d = S_ARB;
            end
            S_ARB: begin
                if (arb_found) begin
                    sel_d   = arb_sel;
                    hdr_d   = dest[arb_sel];
                    state_d = S_ROUTE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ROUTE: begin
                dir_d   = route_dir;
                state_d = S_GRANT;
            end
            S_GRANT: begin
                if (free_q[dir_q]) begin
                    free_d[dir_q]                     = 1'b0;
                    mux_in_d[32'(dir_q)*PW +: PW]     = sel_q;
                    mux_out_d[32'(sel_q)*PW +: PW]    = dir_q;
                    ack_d[sel_q]                      = 1'b1;
`ifdef ROUTER_GRANT_CNT_EN
                    cnt_d[32'(dir_q)*CW +: CW] = cnt_q[32'(dir_q)*CW +: CW] + CW'(1);
`endif
                end
                ptr_d   = sel_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= P_LOCAL;
            sel_q     <= '0;
            dir_q     <= '0;
            hdr_q     <= '0;
            ack_q     <= '0;
            free_q    <= '1;
            mux_in_q  <= '0;
            mux_out_q <= '0;
            sender_q  <= '0;
`ifdef ROUTER_GRANT_CNT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            dir_q     <= dir_d;
            hdr_q     <= hdr_d;
            ack_q     <= ack_d;
            free_q    <= free_d;
            mux_in_q  <= mux_in_d;
            mux_out_q <= mux_out_d;
            sender_q  <= sender;
`ifdef ROUTER_GRANT_CNT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign ack_h   = ack_q;
    assign free    = free_q;
    assign mux_in  = mux_in_q;
    assign mux_out = mux_out_q;
`ifdef ROUTER_GRANT_CNT_EN
    assign grant_cnt = cnt_q;
`endif

endmodule
